// File: rtl/fm_radio_pkg.sv
// Shared fixed-point constants, coefficient tables and the product dequantizer for the FM radio chain.
// Build with FIR_DEQUANT_ROUND_EN defined to round half away from zero instead of truncating toward zero.
package fm_radio_pkg;

    localparam int DATA_SIZE  = 32;
    localparam int QUANT_BITS = 10;
    localparam int PROD_W     = 2 * DATA_SIZE;
    localparam int AUDIO_TAPS = 32;

    typedef logic [0:AUDIO_TAPS-1][DATA_SIZE-1:0] audio_coeffs_t;

    // Symmetric Q10 audio low-pass, element 0 applies to the newest sample.
    localparam audio_coeffs_t AUDIO_LPR_COEFFS = '{
        -32'sd1,  -32'sd2,  -32'sd2,   32'sd0,   32'sd3,   32'sd6,   32'sd8,   32'sd8,
         32'sd5,   32'sd0,  -32'sd6, -32'sd10,  -32'sd8,   32'sd4,  32'sd28,  32'sd60,
        32'sd60,  32'sd28,   32'sd4,  -32'sd8, -32'sd10,  -32'sd6,   32'sd0,   32'sd5,
         32'sd8,   32'sd8,   32'sd6,   32'sd3,   32'sd0,  -32'sd2,  -32'sd2,  -32'sd1
    };

    // Scale a full-width Q10*Q10 product back to Q10, symmetric about zero.
    function automatic logic [DATA_SIZE-1:0] dequantize(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] mag;
        mag = p[PROD_W-1] ? -p : p;
`ifdef FIR_DEQUANT_ROUND_EN
        mag = mag + PROD_W'(1 << (QUANT_BITS - 1));
`endif
        mag = mag >>> QUANT_BITS;
        return DATA_SIZE'(p[PROD_W-1] ? -mag : mag);
    endfunction

endpackage

// File: rtl/fir_decim_if.sv
// Sample-in / sample-out FIFO handshake of the decimating FIR.
// master is the filter side, slave is the FIFO side.
interface fir_decim_if #(
    parameter int DATA_SIZE = fm_radio_pkg::DATA_SIZE
);
    logic [DATA_SIZE-1:0] x_in;
    logic                 x_rd_en;
    logic                 x_empty;
    logic [DATA_SIZE-1:0] y_out;
    logic                 y_out_full;
    logic                 y_wr_en;

    modport master (
        input  x_in, x_empty, y_out_full,
        output x_rd_en, y_out, y_wr_en
    );

    modport slave (
        output x_in, x_empty, y_out_full,
        input  x_rd_en, y_out, y_wr_en
    );
endinterface

// File: rtl/fir_decim.sv
// Decimating real FIR: pops DECIMATION samples, runs one MAC per tap, then pushes the Q10 sum.
// Product scaling comes from fm_radio_pkg::dequantize (FIR_DEQUANT_ROUND_EN selects rounding).
//
// state      | meaning
// ST_READ    | pop input samples into the history line until DECIMATION have arrived
// ST_COMPUTE | accumulate one coefficient*history product per cycle, TAPS cycles
// ST_WRITE   | present the accumulator, push it once the output FIFO has room
module fir_decim #(
    parameter int TAPS       = 32,
    parameter int DECIMATION = 8,
    parameter int DATA_SIZE  = fm_radio_pkg::DATA_SIZE,
    parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFFS = fm_radio_pkg::AUDIO_LPR_COEFFS
) (
    input logic         clock,
    input logic         reset,
    fir_decim_if.master bus
);

    localparam int TAP_W      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CNT_W      = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int MUL_W      = 2 * DATA_SIZE;
    localparam int PKG_PROD_W = fm_radio_pkg::PROD_W;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIMATION - 1);

    typedef enum logic [1:0] {
        ST_READ    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_WRITE   = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic signed [DATA_SIZE-1:0] hist_q [TAPS];
    logic signed [DATA_SIZE-1:0] hist_d [TAPS];
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic [DATA_SIZE-1:0]        acc_q, acc_d;

    logic signed [MUL_W-1:0]     coef_ext;
    logic signed [MUL_W-1:0]     samp_ext;
    logic signed [MUL_W-1:0]     prod;
    logic [fm_radio_pkg::DATA_SIZE-1:0] deq;

    always_comb begin
        coef_ext = MUL_W'($signed(COEFFS[tap_q]));
        samp_ext = MUL_W'(hist_q[tap_q]);
        prod     = coef_ext * samp_ext;
        deq      = fm_radio_pkg::dequantize(PKG_PROD_W'(prod));
    end

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        bus.x_rd_en = 1'b0;
        bus.y_wr_en = 1'b0;

        case (state_q)
            ST_READ: begin
                bus.x_rd_en = !bus.x_empty;
                if (!bus.x_empty) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    hist_d[0] = bus.x_in;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        tap_d   = '0;
                        acc_d   = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ST_COMPUTE: begin
                acc_d = acc_q + DATA_SIZE'(deq);
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end

            ST_WRITE: begin
                bus.y_wr_en = !bus.y_out_full;
                if (!bus.y_out_full) begin
                    state_d = ST_READ;
                end
            end

            default: state_d = ST_READ;
        endcase
    end

    // Output is the accumulator register itself, so it cannot move while WRITE stalls.
    assign bus.y_out = acc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_READ;
            hist_q  <= '{default: '0};
            cnt_q   <= '0;
            tap_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_fir_decim.sv
// Directed bench for fir_decim: impulse, DC gain, dequantization, backpressure, input gaps, reset.
// Expected rounding follows FIR_DEQUANT_ROUND_EN when the bench is built with it.
module tb_fir_decim;

    localparam int W  = 32;
    localparam int NT = 32;

    localparam int COEF_REF [NT] = '{
        -1, -2, -2,  0,   3,  6,  8,  8,
         5,  0, -6, -10, -8,  4, 28, 60,
        60, 28,  4, -8, -10, -6,  0,  5,
         8,  8,  6,  3,   0, -2, -2, -1
    };
    localparam int DC_EXP [6] = '{20, 93, 166, 186, 186, 186};
    localparam logic [0:1][W-1:0] TRUNC_COEFFS = '{32'd1, 32'd0};
`ifdef FIR_DEQUANT_ROUND_EN
    localparam longint HALF = 512;
    localparam int TRUNC_EXP [3] = '{-2, 2, -1};
`else
    localparam longint HALF = 0;
    localparam int TRUNC_EXP [3] = '{-1, 1, 0};
`endif

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst1_n = 1'b0;
    always #5 clk = ~clk;

    fir_decim_if #(.DATA_SIZE(W)) if1 ();
    fir_decim_if #(.DATA_SIZE(W)) if8 ();
    fir_decim_if #(.DATA_SIZE(W)) ift ();

    fir_decim #(.TAPS(NT), .DECIMATION(1), .DATA_SIZE(W)) dut1 (
        .clock(clk), .reset(rst1_n), .bus(if1)
    );
    fir_decim #(.TAPS(NT), .DECIMATION(8), .DATA_SIZE(W)) dut8 (
        .clock(clk), .reset(rst_n), .bus(if8)
    );
    fir_decim #(.TAPS(2), .DECIMATION(1), .DATA_SIZE(W), .COEFFS(TRUNC_COEFFS)) dutt (
        .clock(clk), .reset(rst_n), .bus(ift)
    );

    logic [W-1:0] src1 [$];
    logic [W-1:0] src8 [$];
    logic [W-1:0] srct [$];
    logic [W-1:0] out1 [$];
    logic [W-1:0] out8 [$];
    logic [W-1:0] outt [$];
    int           seq8 [$];

    logic full1 = 1'b0;
    logic gap8  = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   first_pop1 = -1;
    int   first_wr1 = -1;
    int   rd_viol = 0;
    int   both_viol = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic longint deq_ref(input longint p);
        if (p < 0) return -((-p + HALF) / 1024);
        return (p + HALF) / 1024;
    endfunction

    function automatic logic [W-1:0] golden8(input int n);
        longint acc = 0;
        for (int i = 0; i < NT; i++) begin
            if (n - i >= 0) acc += deq_ref(longint'(COEF_REF[i]) * longint'(seq8[n - i]));
        end
        return acc[31:0];
    endfunction

    // One clock: drive FIFO-side inputs at the falling edge, sample 1ns later, then advance.
    task automatic tick();
        if1.x_empty    = (src1.size() == 0);
        if1.x_in       = (src1.size() != 0) ? src1[0] : '0;
        if1.y_out_full = full1;
        if8.x_empty    = (src8.size() == 0) || (gap8 && ($urandom_range(1) == 0));
        if8.x_in       = (src8.size() != 0) ? src8[0] : '0;
        if8.y_out_full = 1'b0;
        ift.x_empty    = (srct.size() == 0);
        ift.x_in       = (srct.size() != 0) ? srct[0] : '0;
        ift.y_out_full = 1'b0;
        #1;
        if (if1.x_rd_en && if1.x_empty) rd_viol++;
        if (if8.x_rd_en && if8.x_empty) rd_viol++;
        if (ift.x_rd_en && ift.x_empty) rd_viol++;
        if (if1.x_rd_en && if1.y_wr_en) both_viol++;
        if (if8.x_rd_en && if8.y_wr_en) both_viol++;
        if (ift.x_rd_en && ift.y_wr_en) both_viol++;
        if (if1.x_rd_en && !if1.x_empty) begin
            void'(src1.pop_front());
            if (first_pop1 < 0) first_pop1 = cyc;
        end
        if (if8.x_rd_en && !if8.x_empty) void'(src8.pop_front());
        if (ift.x_rd_en && !ift.x_empty) void'(srct.pop_front());
        if (if1.y_wr_en) begin
            out1.push_back(if1.y_out);
            if (first_wr1 < 0) first_wr1 = cyc;
        end
        if (if8.y_wr_en) out8.push_back(if8.y_out);
        if (ift.y_wr_en) outt.push_back(ift.y_out);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_impulse(input string tag);
        int guard;
        out1.delete();
        first_pop1 = -1;
        first_wr1  = -1;
        src1.push_back(32'd1024);
        repeat (40) src1.push_back('0);
        guard = 0;
        while (out1.size() < 41 && guard < 3000) begin
            tick();
            guard++;
        end
        chk({tag, " count"}, out1.size(), 41);
        chk({tag, " latency"}, first_wr1 - first_pop1, NT + 1);
        for (int k = 0; k < 41 && k < out1.size(); k++) begin
            if (k < NT) chk($sformatf("%s[%0d]", tag, k), out1[k], COEF_REF[k]);
            else        chk($sformatf("%s[%0d]", tag, k), out1[k], 0);
        end
    endtask

    initial begin
        int guard;
        int n0;
        int stall_bad;

        if1.x_empty = 1'b1; if1.x_in = '0; if1.y_out_full = 1'b0;
        if8.x_empty = 1'b1; if8.x_in = '0; if8.y_out_full = 1'b0;
        ift.x_empty = 1'b1; ift.x_in = '0; ift.y_out_full = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset y_out", if1.y_out, 0);
        chk("reset y_wr_en", if1.y_wr_en, 0);
        chk("reset x_rd_en", if1.x_rd_en, 0);
        chk("reset y_out dec8", if8.y_out, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);

        run_impulse("impulse");

        repeat (48) begin
            src8.push_back(32'd1024);
            seq8.push_back(1024);
        end
        guard = 0;
        while (out8.size() < 6 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("dc count", out8.size(), 6);
        for (int k = 0; k < 6 && k < out8.size(); k++)
            chk($sformatf("dc[%0d]", k), out8[k], DC_EXP[k]);

        srct.push_back(32'hFFFF_FA00);
        srct.push_back(32'h0000_0600);
        srct.push_back(32'hFFFF_FE00);
        guard = 0;
        while (outt.size() < 3 && guard < 200) begin
            tick();
            guard++;
        end
        chk("deq count", outt.size(), 3);
        for (int k = 0; k < 3 && k < outt.size(); k++)
            chk($sformatf("deq[%0d]", k), outt[k], TRUNC_EXP[k]);

        full1 = 1'b1;
        src1.push_back(32'd1024);
        src1.push_back(32'd0);
        n0 = out1.size();
        repeat (NT + 1) tick();
        stall_bad = 0;
        repeat (20) begin
            tick();
            if (if1.y_out !== 32'hFFFF_FFFF) stall_bad++;
        end
        chk("stall no write", out1.size(), n0);
        chk("stall no pop", src1.size(), 1);
        chk("stall x_rd_en", if1.x_rd_en, 0);
        chk("stall y_wr_en", if1.y_wr_en, 0);
        chk("stall y_out value", if1.y_out, 32'hFFFF_FFFF);
        chk("stall y_out held", stall_bad, 0);
        full1 = 1'b0;
        tick();
        chk("release write", out1.size(), n0 + 1);
        if (out1.size() > n0) chk("release value", out1[n0], 32'hFFFF_FFFF);
        tick();
        chk("resume pop", src1.size(), 0);
        chk("single write", out1.size(), n0 + 1);
        repeat (NT + 4) tick();
        chk("resume output count", out1.size(), n0 + 2);
        if (out1.size() > n0 + 1) chk("resume output", out1[n0 + 1], COEF_REF[1]);

        gap8 = 1'b1;
        for (int j = 0; j < 800; j++) begin
            int v;
            v = int'($urandom_range(4095)) - 2048;
            src8.push_back(32'(v));
            seq8.push_back(v);
        end
        guard = 0;
        while ((src8.size() != 0 || out8.size() < 106) && guard < 20000) begin
            tick();
            guard++;
        end
        repeat (NT + 4) tick();
        gap8 = 1'b0;
        chk("gap count", out8.size(), 106);
        for (int k = 6; k < 106 && k < out8.size(); k++)
            chk($sformatf("gap[%0d]", k), out8[k], golden8(8 * k + 7));

        src1.push_back(32'd1024);
        repeat (11) tick();
        rst1_n = 1'b0;
        #1;
        chk("mid reset y_wr_en", if1.y_wr_en, 0);
        chk("mid reset x_rd_en", if1.x_rd_en, 0);
        chk("mid reset y_out", if1.y_out, 0);
        @(negedge clk);
        repeat (2) tick();
        rst1_n = 1'b1;
        tick();
        run_impulse("impulse after reset");

        chk("rd only when not empty", rd_viol, 0);
        chk("no rd and wr together", both_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_decim.md
Name: fir_decim

Overview:
- Real-valued decimating FIR (audio low-pass) in the FM radio chain, directly upstream of the de-emphasis IIR.
- Consumes demodulator samples from a FIFO and keeps every DECIMATION-th filtered sample.
- Uses one MAC per cycle.
- Writes Q10 fixed-point results into the FIFO feeding the de-emphasis stage.

Parameters:
- TAPS, 32, number of filter coefficients (>=2).
- DECIMATION, 8, input samples consumed per output (>=1).
- DATA_SIZE, 32, sample/coefficient width, signed Q10.
- COEFFS, fm_radio_pkg::AUDIO_LPR_COEFFS, [0:TAPS-1][DATA_SIZE-1:0] signed coefficients; COEFFS[0] multiplies the newest sample.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- x_in  in  DATA_SIZE  input sample, valid while x_empty=0 (first-word-fall-through FIFO)
- x_rd_en  out  1  pops input FIFO this cycle
- x_empty  in  1  input FIFO empty
- y_out  out  DATA_SIZE  filtered decimated sample
- y_out_full  in  1  output FIFO full
- y_wr_en  out  1  pushes y_out this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=READ.
  - History x[0:TAPS-1]=0, decimation count=0, tap index=0, accumulator=0.
  - y_out=0, y_wr_en=0, x_rd_en=0.
  - Reset mid-operation discards the partial sum and all history.
- READ:
  - x_rd_en=!x_empty (combinational).
  - On a pop: x[1:TAPS-1]<=x[0:TAPS-2], x[0]<=x_in, count<=(count+1)%DECIMATION.
  - Pop with count==DECIMATION-1 -> COMPUTE, with tap index=0 and accumulator=0. Otherwise stay in READ.
  - x_empty=1 -> hold everything.
- COMPUTE:
  - One tap per cycle: acc<=acc+DEQ(COEFFS[i]*x[i]), i=0..TAPS-1.
  - After i==TAPS-1 -> WRITE. Exactly TAPS cycles.
  - x_rd_en=0 throughout.
- Arithmetic:
  - Product is a 2*DATA_SIZE signed full product.
  - DEQ truncates toward zero: neg ? -((-p)>>>10) : p>>>10, then takes the low DATA_SIZE bits.
  - Accumulator is DATA_SIZE wide, wraps modulo 2^DATA_SIZE, no saturation.
- WRITE:
  - y_out is driven from the registered accumulator and is stable throughout WRITE.
  - y_wr_en=!y_out_full (combinational). On the write -> READ.
  - y_out_full=1 -> stall indefinitely; no input pops, accumulator and history frozen.
- Latency:
  - First output write occurs TAPS+1 cycles after the DECIMATION-th pop (given no backpressure).
  - Throughput: one output per DECIMATION pops + TAPS + 1 cycles minimum.
- Boundaries:
  - DECIMATION=1 -> every pop produces an output.
  - Reads and writes never occur in the same cycle.
  - x_empty is ignored outside READ; y_out_full is ignored outside WRITE.
  - Illegal state -> READ.

Optional Feature:
- Macro FIR_DEQUANT_ROUND_EN.
- Defined: DEQ rounds half away from zero: neg ? -(((-p)+512)>>>10) : (p+512)>>>10.
- Undefined: truncation toward zero as above.
- Timing and handshake are identical in both cases.

Decomposition:
- fm_radio_pkg holds:
  - DATA_SIZE and QUANT_BITS=10
  - AUDIO_LPR_COEFFS and the other coefficient arrays
  - DEQUANTIZE function, with the macro-selected rounding inside
- State enum stays local to fir_decim.
- No sub-module: MAC is a single multiplier plus accumulator, inline.

Test Plan:
- Impulse (DECIMATION=1): feed 1024 then 40 zeros -> outputs equal COEFFS[0..31] in order, then 0s; first y_wr_en TAPS+1 cycles after the first pop.
- DC gain (DECIMATION=8): constant 1024 -> outputs sum(COEFFS[0..7]), sum(COEFFS[0..15]), sum(COEFFS[0..23]), then sum(all COEFFS) repeated.
- Truncation, single nonzero coefficient COEFFS[0]=1, input -1536 -> y_out=-1 without FIR_DEQUANT_ROUND_EN; -2 with it.
- Backpressure: y_out_full=1 for 20 cycles in WRITE -> y_wr_en=0 and x_rd_en=0, y_out constant. Release -> exactly one write, then READ resumes.
- Empty gaps: x_empty random 50% over 800 samples (DECIMATION=8) -> x_rd_en only when x_empty=0; exactly 100 outputs matching the golden model.
- Reset low during COMPUTE -> y_wr_en/x_rd_en/y_out=0 immediately. After release, impulse test output identical to the first scenario (history cleared).
